// File: rtl/ysyx_25040129_mem_arbiter.sv
// ysyx_25040129_mem_arbiter: arbitrates IFU and LSU AXI-lite traffic onto the MMU port,
// one single-beat transaction at a time, with satp latched at grant.
module ysyx_25040129_mem_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] satp,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    input  logic [2:0]  ifu_arsize,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    input  logic [2:0]  lsu_arsize,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    output logic [2:0]  m_arsize,
    output logic [7:0]  m_arlen,
    output logic [1:0]  m_arburst,
    output logic [31:0] m_arsatp,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    output logic [31:0] m_awsatp,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);
    typedef enum logic [2:0] {IDLE, IFU_RD, LSU_RD, LSU_WR, LSU_B} state_e;

    state_e      state_q;
    logic [31:0] sat_q;
    logic        last_lsu_q, aw_done_q, w_done_q;
    logic        in_ifu, in_lr, in_wr, in_b;
    logic        lsu_wr_req, lsu_req, grant_ifu;
    logic        aw_now, w_now, b_ok, b_hs, unused;

    assign unused     = m_rlast;
    assign in_ifu     = state_q == IFU_RD;
    assign in_lr      = state_q == LSU_RD;
    assign in_wr      = state_q == LSU_WR;
    assign in_b       = state_q == LSU_B;
    assign lsu_wr_req = lsu_awvalid & lsu_wvalid;
    assign lsu_req    = lsu_wr_req | lsu_arvalid;
    // On a tie the IFU wins only when round-robin is on and the LSU went last.
    assign grant_ifu  = ifu_arvalid & (~lsu_req | (RR & last_lsu_q));

    assign m_araddr  = in_ifu ? ifu_araddr : lsu_araddr;
    assign m_arsize  = in_ifu ? ifu_arsize : lsu_arsize;
    assign m_arvalid = (in_ifu & ifu_arvalid) | (in_lr & lsu_arvalid);
    assign m_arlen   = 8'd0;
    assign m_arburst = 2'b01;
    assign m_arsatp  = sat_q;
    assign m_awsatp  = sat_q;
    assign m_rready  = (in_ifu & ifu_rready) | (in_lr & lsu_rready);

    assign ifu_arready = in_ifu & m_arready;
    assign ifu_rvalid  = in_ifu & m_rvalid;
    assign ifu_rdata   = m_rdata;
    assign ifu_rresp   = m_rresp;
    assign lsu_arready = in_lr & m_arready;
    assign lsu_rvalid  = in_lr & m_rvalid;
    assign lsu_rdata   = m_rdata;
    assign lsu_rresp   = m_rresp;

    assign m_awaddr    = lsu_awaddr;
    assign m_wdata     = lsu_wdata;
    assign m_wstrb     = lsu_wstrb;
    assign m_awvalid   = in_wr & lsu_awvalid & ~aw_done_q;
    assign m_wvalid    = in_wr & lsu_wvalid & ~w_done_q;
    assign lsu_awready = in_wr & m_awready & ~aw_done_q;
    assign lsu_wready  = in_wr & m_wready & ~w_done_q;
    assign aw_now      = aw_done_q | (m_awvalid & m_awready);
    assign w_now       = w_done_q | (m_wvalid & m_wready);
    // The response path opens as soon as both halves are accepted, even mid-LSU_WR.
    assign b_ok        = in_b | (in_wr & aw_now & w_now);
    assign lsu_bvalid  = b_ok & m_bvalid;
    assign lsu_bresp   = m_bresp;
    assign m_bready    = b_ok & lsu_bready;
    assign b_hs        = m_bvalid & m_bready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sat_q      <= '0;
            last_lsu_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ifu_arvalid | lsu_req) begin
                    sat_q      <= satp;
                    last_lsu_q <= ~grant_ifu;
                    state_q    <= grant_ifu ? IFU_RD : (lsu_wr_req ? LSU_WR : LSU_RD);
                end
                IFU_RD, LSU_RD: if (m_rvalid & m_rready) state_q <= IDLE;
                LSU_WR: begin
                    aw_done_q <= aw_now & ~b_hs;
                    w_done_q  <= w_now & ~b_hs;
                    if (aw_now & w_now) state_q <= b_hs ? IDLE : LSU_B;
                end
                LSU_B: if (b_hs) begin
                    state_q   <= IDLE;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// tb_ysyx_25040129_mem_arbiter: drives RR=1 and RR=0 arbiters with random request mixes
// and MMU delays, predicting grant order and channel routing from a transaction-level model.
module tb_ysyx_25040129_mem_arbiter;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] satp, ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, m_rdata;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready;
    logic [2:0]  ifu_arsize, lsu_arsize;
    logic [3:0]  lsu_wstrb;
    logic        m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid;
    logic [1:0]  m_rresp, m_bresp;

    logic        ifu_arready_w [2], ifu_rvalid_w [2], lsu_arready_w [2], lsu_rvalid_w [2];
    logic        lsu_awready_w [2], lsu_wready_w [2], lsu_bvalid_w [2];
    logic        m_arvalid_w [2], m_awvalid_w [2], m_wvalid_w [2], m_bready_w [2], m_rready_w [2];
    logic [31:0] ifu_rdata_w [2], lsu_rdata_w [2], m_araddr_w [2], m_arsatp_w [2];
    logic [31:0] m_awaddr_w [2], m_awsatp_w [2], m_wdata_w [2];
    logic [1:0]  ifu_rresp_w [2], lsu_rresp_w [2], lsu_bresp_w [2], m_arburst_w [2];
    logic [2:0]  m_arsize_w [2];
    logic [7:0]  m_arlen_w [2];
    logic [3:0]  m_wstrb_w [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_25040129_mem_arbiter #(.RR(g == 0)) u_dut (
            .clk(clk), .rst(rst), .satp(satp),
            .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arsize(ifu_arsize),
            .ifu_arready(ifu_arready_w[g]), .ifu_rdata(ifu_rdata_w[g]), .ifu_rresp(ifu_rresp_w[g]),
            .ifu_rvalid(ifu_rvalid_w[g]), .ifu_rready(ifu_rready),
            .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arsize(lsu_arsize),
            .lsu_arready(lsu_arready_w[g]), .lsu_rdata(lsu_rdata_w[g]), .lsu_rresp(lsu_rresp_w[g]),
            .lsu_rvalid(lsu_rvalid_w[g]), .lsu_rready(lsu_rready),
            .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready_w[g]),
            .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
            .lsu_wready(lsu_wready_w[g]), .lsu_bresp(lsu_bresp_w[g]), .lsu_bvalid(lsu_bvalid_w[g]),
            .lsu_bready(lsu_bready),
            .m_araddr(m_araddr_w[g]), .m_arvalid(m_arvalid_w[g]), .m_arsize(m_arsize_w[g]),
            .m_arlen(m_arlen_w[g]), .m_arburst(m_arburst_w[g]), .m_arsatp(m_arsatp_w[g]),
            .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
            .m_rlast(m_rlast), .m_rready(m_rready_w[g]),
            .m_awaddr(m_awaddr_w[g]), .m_awvalid(m_awvalid_w[g]), .m_awsatp(m_awsatp_w[g]),
            .m_awready(m_awready), .m_wdata(m_wdata_w[g]), .m_wstrb(m_wstrb_w[g]),
            .m_wvalid(m_wvalid_w[g]), .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
            .m_bready(m_bready_w[g])
        );
    end

    int tests = 0, fails = 0;
    int s = 0;
    bit rr_mode = 1'b1, satp_rand = 1'b1, last_lsu = 1'b1;
    int fx_ar = -1, fx_r = -1, fx_aw = -1, fx_w = -1, fx_b = -1;
    logic [31:0] sat_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    function automatic int dly(input int f);
        return f >= 0 ? f : int'($urandom_range(0, 3));
    endfunction

    task automatic idle_chk(input string tag);
        chk(tag, 32'({m_arvalid_w[s], m_awvalid_w[s], m_wvalid_w[s], m_rready_w[s], m_bready_w[s],
                      ifu_rvalid_w[s], lsu_rvalid_w[s], lsu_bvalid_w[s], ifu_arready_w[s],
                      lsu_arready_w[s], lsu_awready_w[s], lsu_wready_w[s]}), 32'd0);
    endtask

    task automatic clear_inputs;
        {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid} = '0;
        {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid} = '0;
        {m_rdata, m_rresp, m_bresp} = '0;
        {ifu_rready, lsu_rready, lsu_bready} = 3'b111;
    endtask

    task automatic do_reset;
        nxt();
        rst = 1'b0;
        clear_inputs();
        nxt();
        #1;
        idle_chk("reset_idle");
        chk("reset_arsatp", m_arsatp_w[s], 32'd0);
        chk("reset_awsatp", m_awsatp_w[s], 32'd0);
        rst = 1'b1;
        last_lsu = 1'b1;
    endtask

    task automatic serve_read(input bit lsu);
        int dar = dly(fx_ar), dr = dly(fx_r);
        for (int c = 0; c <= dar + dr + 1; c++) begin
            nxt();
            m_arready = c == dar;
            m_rvalid  = c == dar + dr + 1;
            m_rdata   = $urandom;
            m_rresp   = 2'($urandom_range(0, 3));
            satp      = satp_rand ? $urandom : 32'd0;
            if (c == dar + 1) begin
                if (lsu) lsu_arvalid = 1'b0;
                else ifu_arvalid = 1'b0;
            end
            #1;
            chk("rd_arvalid", 32'(m_arvalid_w[s]), 32'(c <= dar));
            if (c <= dar) begin
                chk("rd_araddr", m_araddr_w[s], lsu ? lsu_araddr : ifu_araddr);
                chk("rd_arsize", 32'(m_arsize_w[s]), 32'(lsu ? lsu_arsize : ifu_arsize));
                chk("rd_arlen_burst", 32'({m_arlen_w[s], m_arburst_w[s]}), 32'h1);
            end
            chk("rd_satp", m_arsatp_w[s], sat_exp);
            chk("rd_no_aw", 32'({m_awvalid_w[s], m_wvalid_w[s], m_bready_w[s]}), 32'd0);
            chk("rd_arready", 32'({ifu_arready_w[s], lsu_arready_w[s]}),
                32'({!lsu && c == dar, lsu && c == dar}));
            chk("rd_rvalid", 32'({ifu_rvalid_w[s], lsu_rvalid_w[s]}),
                32'({!lsu && m_rvalid, lsu && m_rvalid}));
            chk("rd_rready", 32'(m_rready_w[s]), 32'd1);
            if (m_rvalid) begin
                chk("rd_rdata", lsu ? lsu_rdata_w[s] : ifu_rdata_w[s], m_rdata);
                chk("rd_rresp", 32'(lsu ? lsu_rresp_w[s] : ifu_rresp_w[s]), 32'(m_rresp));
            end
        end
    endtask

    task automatic serve_write;
        int daw = dly(fx_aw), dw = dly(fx_w), db = dly(fx_b);
        int both = daw > dw ? daw : dw;
        for (int c = 0; c <= both + db; c++) begin
            nxt();
            m_awready = c == daw;
            m_wready  = c == dw;
            m_bvalid  = c == both + db;
            m_bresp   = 2'($urandom_range(0, 3));
            satp      = satp_rand ? $urandom : 32'd0;
            #1;
            chk("wr_awvalid", 32'(m_awvalid_w[s]), 32'(c <= daw));
            chk("wr_wvalid", 32'(m_wvalid_w[s]), 32'(c <= dw));
            if (c == 0) begin
                chk("wr_awaddr", m_awaddr_w[s], lsu_awaddr);
                chk("wr_wdata", m_wdata_w[s], lsu_wdata);
                chk("wr_wstrb", 32'(m_wstrb_w[s]), 32'(lsu_wstrb));
            end
            chk("wr_satp", m_awsatp_w[s], sat_exp);
            chk("wr_no_ar", 32'({m_arvalid_w[s], m_rready_w[s], ifu_arready_w[s], lsu_arready_w[s]}), 32'd0);
            chk("wr_readies", 32'({lsu_awready_w[s], lsu_wready_w[s]}), 32'({c == daw, c == dw}));
            chk("wr_bready", 32'(m_bready_w[s]), 32'(c >= both));
            chk("wr_bvalid", 32'(lsu_bvalid_w[s]), 32'(c == both + db));
            if (m_bvalid) chk("wr_bresp", 32'(lsu_bresp_w[s]), 32'(m_bresp));
        end
    endtask

    // Model: with every request raised at once and held, the service order follows
    // directly from the grant rules and the remembered last grant.
    task automatic round(input bit fi, input bit flr, input bit flw);
        int order[$];
        bit pi = fi, pr = flr, pw = flw;
        while (pi || pr || pw) begin
            if (pi && (!(pr || pw) || (rr_mode && last_lsu))) begin
                order.push_back(0);
                pi = 1'b0;
                last_lsu = 1'b0;
            end else begin
                order.push_back(pw ? 2 : 1);
                if (pw) pw = 1'b0;
                else pr = 1'b0;
                last_lsu = 1'b1;
            end
        end
        nxt();
        ifu_arvalid = fi;
        lsu_arvalid = flr;
        lsu_awvalid = flw;
        lsu_wvalid  = flw;
        ifu_araddr  = 32'h8000_0000 | ($urandom & 32'h3fff_fffc);
        lsu_araddr  = 32'h4000_0000 | ($urandom & 32'h3fff_fffc);
        lsu_awaddr  = $urandom;
        lsu_wdata   = $urandom;
        lsu_wstrb   = 4'($urandom_range(1, 15));
        ifu_arsize  = 3'($urandom_range(0, 2));
        lsu_arsize  = 3'($urandom_range(0, 2));
        if (satp_rand) satp = $urandom;
        sat_exp = satp;
        #1;
        idle_chk("raise_idle");
        foreach (order[k]) begin
            if (order[k] == 2) serve_write();
            else serve_read(order[k] == 1);
            nxt();
            {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
            if (order[k] == 2) {lsu_awvalid, lsu_wvalid} = 2'b00;
            if (satp_rand) satp = $urandom;
            sat_exp = satp;
            #1;
            idle_chk("bubble_idle");
        end
    endtask

    task automatic random_round;
        bit fi, flr, flw;
        do begin
            fi  = ($urandom & 1) != 0;
            flr = ($urandom & 1) != 0;
            flw = ($urandom & 1) != 0;
        end while (!(fi || flr || flw));
        round(fi, flr, flw);
    endtask

    initial begin
        satp = 32'd0;
        {ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, lsu_wstrb, ifu_arsize, lsu_arsize} = '0;
        clear_inputs();
        rr_mode = 1'b1;
        s = 0;
        do_reset();
        fx_ar = 2; fx_r = 2;
        round(1, 0, 0);
        fx_ar = -1; fx_r = -1;
        do_reset();
        round(1, 1, 0);
        round(1, 0, 0);
        round(1, 1, 0);
        fx_aw = 0; fx_w = 0; fx_b = 0;
        round(0, 0, 1);
        fx_aw = 1; fx_w = 3; fx_b = 1;
        round(0, 0, 1);
        fx_aw = -1; fx_w = -1; fx_b = -1;
        satp_rand = 1'b0;
        satp = 32'h8000_0010;
        round(0, 1, 0);
        satp_rand = 1'b1;
        round(1, 1, 1);
        nxt();
        lsu_awvalid = 1'b1;
        lsu_wvalid  = 1'b1;
        lsu_awaddr  = 32'h8000_0100;
        lsu_wdata   = 32'hdead_beef;
        lsu_wstrb   = 4'b0011;
        nxt();
        {m_awready, m_wready} = 2'b11;
        nxt();
        {m_awready, m_wready} = 2'b00;
        #1;
        chk("lsu_b_bready", 32'({m_bready_w[s], m_awvalid_w[s], m_wvalid_w[s]}), 32'b100);
        nxt();
        rst = 1'b0;
        {lsu_awvalid, lsu_wvalid} = 2'b00;
        nxt();
        rst = 1'b1;
        m_bvalid = 1'b1;
        last_lsu = 1'b1;
        #1;
        idle_chk("rst_in_b_idle");
        chk("rst_in_b_satp", m_arsatp_w[s], 32'd0);
        nxt();
        m_bvalid = 1'b0;
        round(1, 0, 0);
        for (int i = 0; i < 30; i++) random_round();
        rr_mode = 1'b0;
        s = 1;
        do_reset();
        round(1, 1, 0);
        round(1, 1, 0);
        round(1, 1, 1);
        for (int i = 0; i < 20; i++) random_round();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
